// File: rtl/mat_result_streamer_if.sv
// -----------------------------------------------------------------------------
// mat_result_streamer_if
// Bundles the capture request, snapshot sources and valid/ready output stream
// of the matrix result streamer.
//   master : host side (drives start/operands/out_ready, observes the stream)
//   slave  : streamer side
// Signals:
//   start        capture-and-stream request
//   mat_in       flattened N*N matrix, element [i][j] at [(i*N+j)*DATA_W +: DATA_W]
//   scalar_in    ALU result scalar
//   send_scalar  append scalar_in as final word (sampled with start)
//   col_major    0 = row-major, 1 = column-major order (sampled with start)
//   out_data     current stream word
//   out_valid    out_data valid
//   out_ready    downstream accepts the word
//   out_last     final word of the frame
//   busy         frame in progress
//   done         one-cycle pulse after the final transfer
// -----------------------------------------------------------------------------
interface mat_result_streamer_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned N      = 4
);
    localparam int unsigned MAT_W = N * N * DATA_W;

    logic              start;
    logic [MAT_W-1:0]  mat_in;
    logic [DATA_W-1:0] scalar_in;
    logic              send_scalar;
    logic              col_major;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              done;

    modport master (
        output start, mat_in, scalar_in, send_scalar, col_major, out_ready,
        input  out_data, out_valid, out_last, busy, done
    );

    modport slave (
        input  start, mat_in, scalar_in, send_scalar, col_major, out_ready,
        output out_data, out_valid, out_last, busy, done
    );
endinterface

// File: rtl/mat_result_streamer.sv
// -----------------------------------------------------------------------------
// mat_result_streamer
// Snapshots the 4x4 matrix ALU result (and optionally the scalar) on a start
// request and serializes it one word per transfer over a valid/ready stream,
// in row-major or column-major (transposed) order.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset; aborts any frame without a done pulse
//   bus    mat_result_streamer_if.slave (capture inputs + output stream)
// All outputs are registered.
// -----------------------------------------------------------------------------
module mat_result_streamer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned N      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    mat_result_streamer_if.slave  bus
);
    localparam int unsigned NN    = N * N;
    localparam int unsigned MAT_W = NN * DATA_W;
    localparam int unsigned K_W   = $clog2(NN + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    // State and snapshot
    logic [1:0]        r_state;
    logic [K_W-1:0]    r_k;
    logic [MAT_W-1:0]  r_mat;
    logic [DATA_W-1:0] r_scalar;
    logic              r_send;
    logic              r_col;

    // Registered outputs
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_out_last;
    logic              r_busy;
    logic              r_done;

    // Next-state values
    logic [1:0]        w_state_nxt;
    logic [K_W-1:0]    w_k_nxt;
    logic [DATA_W-1:0] w_data_nxt;
    logic              w_valid_nxt;
    logic              w_last_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_capture;
    logic [K_W-1:0]    w_last_idx;
    logic [K_W-1:0]    w_k_inc;

    // Word k of a frame: matrix element in the requested order, scalar past N*N
    function automatic logic [DATA_W-1:0] sel_word(
        input logic [MAT_W-1:0]  mat,
        input logic [DATA_W-1:0] scal,
        input logic              col,
        input logic [K_W-1:0]    k
    );
        int unsigned ki;
        int unsigned ei;
        ki = 32'(k);
        if (ki >= NN) begin
            return scal;
        end
        ei = col ? ((ki % N) * N + ki / N) : ki;
        return mat[ei * DATA_W +: DATA_W];
    endfunction

    // Index of the final word: N*N-1, or N*N when the scalar is appended
    assign w_last_idx = K_W'(NN - 1) + K_W'(r_send);
    assign w_k_inc    = r_k + K_W'(1);

    // Next-state / next-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_data_nxt  = r_out_data;
        w_valid_nxt = r_out_valid;
        w_last_nxt  = r_out_last;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_capture   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_valid_nxt = 1'b0;
                w_last_nxt  = 1'b0;
                w_busy_nxt  = 1'b0;
                if (bus.start) begin
                    // Word 0 comes straight from the inputs being captured,
                    // so it can be presented in the first cycle of the frame.
                    w_capture   = 1'b1;
                    w_k_nxt     = '0;
                    w_data_nxt  = sel_word(bus.mat_in, bus.scalar_in,
                                           bus.col_major, K_W'(0));
                    w_valid_nxt = 1'b1;
                    w_last_nxt  = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_STREAM;
                end
            end

            S_STREAM: begin
                if (r_out_valid && bus.out_ready) begin
                    if (r_k == w_last_idx) begin
                        w_data_nxt  = '0;
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_k_nxt     = w_k_inc;
                        w_data_nxt  = sel_word(r_mat, r_scalar, r_col, w_k_inc);
                        w_valid_nxt = 1'b1;
                        w_last_nxt  = (w_k_inc == w_last_idx);
                    end
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_data_nxt  = '0;
                w_valid_nxt = 1'b0;
                w_last_nxt  = 1'b0;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counter and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_k         <= w_k_nxt;
            r_out_data  <= w_data_nxt;
            r_out_valid <= w_valid_nxt;
            r_out_last  <= w_last_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    // Snapshot registers, loaded only when a start is accepted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mat    <= '0;
            r_scalar <= '0;
            r_send   <= 1'b0;
            r_col    <= 1'b0;
        end else if (w_capture) begin
            r_mat    <= bus.mat_in;
            r_scalar <= bus.scalar_in;
            r_send   <= bus.send_scalar;
            r_col    <= bus.col_major;
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule

// File: doc/mat_result_streamer.md
Name: mat_result_streamer

Overview:
- Output-side companion to the team's 4x4 floating-point matrix ALU.
- On a start pulse it snapshots the ALU's parallel result matrix, plus the result scalar when requested.
- It then serializes the snapshot one 32-bit word at a time over a valid/ready stream toward the host/DMA side.
- Supports row-major order, and column-major order (a transposed stream).

Parameters:
- DATA_W, 32, width of one IEEE 754 single-precision word.
- N, 4, matrix dimension. The matrix holds N*N elements.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request to capture and stream; sampled only in IDLE.
- mat_in  input  N*N*DATA_W  flattened matrix; element [i][j] at bits [(i*N+j)*DATA_W +: DATA_W].
- scalar_in  input  DATA_W  ALU result scalar.
- send_scalar  input  1  sampled with start; when 1, scalar_in is appended as the final word.
- col_major  input  1  sampled with start; 0 = row-major order, 1 = column-major order.
- out_data  output  DATA_W  current stream word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts the word.
- out_last  output  1  marks the final word of the frame.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse after the final transfer.

Behaviour:
- Reset (reset=0, asynchronous):
  - state goes to IDLE.
  - out_data=0, out_valid=0, out_last=0, busy=0, done=0.
  - Snapshot registers and word counter are cleared.
  - Reset asserted mid-frame aborts the frame. No done pulse is generated.
- States: IDLE, STREAM, DONE.
- IDLE:
  - On start=1, register mat_in, scalar_in, send_scalar and col_major into the snapshot, set word counter k=0, go to STREAM.
  - Cycle t = start edge. At t+1: busy=1, out_valid=1, out_data = word 0.
  - Later changes on mat_in/scalar_in do not affect the frame.
- STREAM, word selection:
  - For k < N*N, row-major sends element [k/N][k%N]; column-major sends element [k%N][k/N].
  - If send_scalar=1, word N*N is the snapshot scalar.
  - Frame length L = N*N + send_scalar, i.e. 16 or 17.
- STREAM, handshake:
  - A transfer occurs on a rising edge with out_valid=1 and out_ready=1.
  - On transfer with k < L-1: k increments, and the next word appears in the following cycle with out_valid kept high. Back-to-back throughput is 1 word/cycle.
  - While out_valid=1 and out_ready=0: out_data, out_last and out_valid hold stable.
  - out_valid never drops mid-frame.
  - out_last=1 exactly while word L-1 is presented.
  - On transfer of word L-1: go to DONE. out_valid=0 and out_last=0 next cycle.
- DONE:
  - One cycle with done=1 and busy=0, then IDLE.
  - start in the DONE cycle is ignored.
- start during STREAM or DONE is ignored. No queuing.
- out_ready while out_valid=0 has no effect.
- Counter width is ceil(log2(N*N+1)) bits. No wrap occurs because the frame ends at L-1.
- Minimum frame time with out_ready held high: start at t, word 0 at t+1, last transfer at edge t+L, done high in cycle t+L+1, IDLE again at t+L+2.

Test Plan:
- Row-major, ready=1:
  - Stimulus: element [i][j]=i*4+j, send_scalar=0, start at t.
  - Required: out_data = 0,1,...,15 on cycles t+1..t+16; out_last only on word 15; done pulse at t+17; busy low afterwards.
- Column-major with scalar:
  - Stimulus: same matrix, col_major=1, send_scalar=1, scalar_in=32'h3F800000.
  - Required: 17 words 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15,32'h3F800000; out_last on the scalar word only.
- Backpressure:
  - Stimulus: row-major frame, out_ready=0 while word 3 is presented for 3 cycles.
  - Required: out_data=3 and out_valid=1 held all 3 cycles; word 4 follows after ready returns; no word dropped or duplicated; 16 transfers total.
- Snapshot isolation and start-while-busy:
  - Stimulus: change mat_in to all 32'hFFFFFFFF and pulse start at word 5.
  - Required: remaining words still 5..15 from the original matrix; exactly one frame is produced.
- Reset mid-frame:
  - Stimulus: drive reset=0 asynchronously (between clock edges) while word 7 is presented.
  - Required: out_valid, out_last, busy and out_data go to 0 immediately, no done pulse. After release, a new start streams from word 0.
- Back-to-back frames:
  - Stimulus: start held high continuously.
  - Required: frames begin every L+2 cycles; each frame has exactly L transfers and one done pulse.
